// File: rtl/cla12_pg_stage.sv
// Generate/propagate front-end of the 12-bit carry-lookahead adder.
// Latency: 1 cycle from accept to out_valid when empty; 1 beat/cycle throughput.
// Backpressure: output register plus one-entry skid; in_ready is ~skid_valid (registered only).
module cla12_pg_stage #(
    parameter int GROUPS  = 3,
    parameter int GROUP_W = 4,
    parameter int N       = GROUPS * GROUP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      a,
    input  logic [N-1:0]      b,
    input  logic              cin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      bit_p,
    output logic [N-1:0]      bit_g,
    output logic [GROUPS-1:0] grp_p,
    output logic [GROUPS-1:0] grp_g,
    output logic              cin_q
);

    // One result record: everything derived from a beat travels together with its carry-in.
    typedef struct packed {
        logic [N-1:0]      bit_p;
        logic [N-1:0]      bit_g;
        logic [GROUPS-1:0] grp_p;
        logic [GROUPS-1:0] grp_g;
        logic              cin;
    } pg_rec_t;

    // State encoding is {skid_valid, out_valid}; 2'b10 is unreachable.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    pg_rec_t           r_out;
    pg_rec_t           r_skid;
    pg_rec_t           w_rec;
    logic [N-1:0]      w_bit_p;
    logic [N-1:0]      w_bit_g;
    logic [GROUPS-1:0] w_grp_p;
    logic [GROUPS-1:0] w_grp_g;
    logic              w_accept;
    logic              w_xfer;
    logic              w_load_out;
    logic              w_out_from_skid;
    logic              w_load_skid;

    // Ripple of the group-generate term from the LSB: equivalent to
    // g3 | p3&g2 | p3&p2&g1 | p3&p2&p1&g0 for a 4-bit group.
    function automatic logic f_grp_gen(input logic [GROUP_W-1:0] p, input logic [GROUP_W-1:0] g);
        logic c;
        c = 1'b0;
        for (int j = 0; j < GROUP_W; j++) begin
            c = g[j] | (p[j] & c);
        end
        return c;
    endfunction

    // XOR propagate is required: the sum stage forms sum = bit_p ^ carry.
    assign w_bit_p = a ^ b;
    assign w_bit_g = a & b;

    for (genvar gk = 0; gk < GROUPS; gk++) begin : g_grp
        assign w_grp_p[gk] = &w_bit_p[gk*GROUP_W +: GROUP_W];
        assign w_grp_g[gk] = f_grp_gen(w_bit_p[gk*GROUP_W +: GROUP_W],
                                       w_bit_g[gk*GROUP_W +: GROUP_W]);
    end

    assign w_rec = '{bit_p: w_bit_p, bit_g: w_bit_g, grp_p: w_grp_p, grp_g: w_grp_g, cin: cin};

    // Ready comes straight from the skid flag so there is no out_ready -> in_ready path.
    assign in_ready  = ~r_state[1];
    assign out_valid = r_state[0];
    assign w_accept  = in_valid & in_ready;
    assign w_xfer    = out_valid & out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and register load controls.
    always_comb begin
        w_state_nxt     = r_state;
        w_load_out      = 1'b0;
        w_out_from_skid = 1'b0;
        w_load_skid     = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_load_out  = 1'b1;
                    w_state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_accept && w_xfer) begin
                    w_load_out = 1'b1;
                end else if (w_accept) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = ST_FULL;
                end else if (w_xfer) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_xfer) begin
                    w_load_out      = 1'b1;
                    w_out_from_skid = 1'b1;
                    w_state_nxt     = ST_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // Output register: loads a fresh beat or drains the skid; otherwise holds stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else if (w_load_out) begin
            r_out <= w_out_from_skid ? r_skid : w_rec;
        end
    end

    // Skid register: catches the beat accepted while the output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid <= '0;
        end else if (w_load_skid) begin
            r_skid <= w_rec;
        end
    end

    assign bit_p = r_out.bit_p;
    assign bit_g = r_out.bit_g;
    assign grp_p = r_out.grp_p;
    assign grp_g = r_out.grp_g;
    assign cin_q = r_out.cin;

    // A held skid beat without a valid output beat would break ordering.
    a_no_skid_without_out: assert property (@(posedge clk) disable iff (!rst_n)
        r_state != 2'b10);

endmodule

// File: doc/cla12_pg_stage.md
Name: cla12_pg_stage

Overview:
- Registered generate/propagate front-end of the 12-bit carry-lookahead adder.
- Accepts operand pairs A/B plus carry-in over a valid/ready handshake.
- Computes per-bit and per-4-bit-group generate/propagate terms and presents them, registered, to the downstream lookahead-carry and sum stage.
- Contains an output register plus a one-entry skid buffer, giving full throughput under backpressure with no combinational ready path from output to input.

Parameters:
- GROUPS, 3, number of lookahead groups.
- GROUP_W, 4, bits per group; operand width N = GROUPS*GROUP_W = 12.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  stage can accept a beat.
- a  input  N  operand A.
- b  input  N  operand B.
- cin  input  1  adder carry-in.
- out_valid  output  1  registered result valid.
- out_ready  input  1  downstream accepts result.
- bit_p  output  N  per-bit propagate, a^b.
- bit_g  output  N  per-bit generate, a&b.
- grp_p  output  GROUPS  group propagate.
- grp_g  output  GROUPS  group generate.
- cin_q  output  1  registered carry-in, aligned with the result.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, skid_valid=0, and bit_p, bit_g, grp_p, grp_g, cin_q all 0.
  - in_ready = ~skid_valid, so it reads 1 during and after reset.
  - Reset mid-transfer discards both held beats; there is no partial output.
- Arithmetic, for each group k, with bits i = k*GROUP_W .. k*GROUP_W+3 and local bits j0..j3:
  - grp_p[k] = AND of bit_p[i] over the group.
  - grp_g[k] = g3 | p3&g2 | p3&p2&g1 | p3&p2&p1&g0.
  - The XOR propagate is mandatory: downstream forms sum = bit_p ^ carry.
  - The values computed from a beat are captured together with cin as one record.
- Handshake:
  - A beat is accepted when in_valid & in_ready.
  - A result transfers when out_valid & out_ready.
  - a, b and cin are sampled only on accept.
- Latency: exactly 1 cycle from accept to out_valid when the stage is empty. Throughput is 1 beat/cycle while out_ready=1.
- State, with skid_valid and out_valid:
  - EMPTY (0,0): accept → load the output register; next state ONE.
  - ONE (0,1):
    - accept & transfer → reload the output register; stay ONE.
    - accept & no transfer → load the skid; next FULL.
    - transfer only → EMPTY.
    - neither → hold.
  - FULL (1,1): in_ready=0 and no accept is possible.
    - transfer → move skid to output register; next ONE.
    - otherwise hold.
  - The state (skid_valid=1, out_valid=0) is illegal; assert it never occurs.
- Ordering: strictly FIFO, with no beat dropped or duplicated.
- Stability: while out_valid=1 and out_ready=0, every output is held stable.
- in_valid deasserted without acceptance: no effect on state.
- in_ready depends only on registered state, never on out_ready or in_valid.

Test Plan:
- Generate/propagate values: reset, then accept a=12'h0FF, b=12'h001, cin=0 with out_ready=1.
  - Next cycle out_valid=1 with bit_p=12'h0FE, bit_g=12'h001, grp_g=3'b001, grp_p=3'b010, cin_q=0.
  - Fed to the lookahead-carry stage, this yields sum 12'h100.
- Full-propagate chain: a=12'hFFF, b=12'h000, cin=1 → bit_p=12'hFFF, bit_g=0, grp_p=3'b111, grp_g=3'b000, cin_q=1.
- Backpressure: out_ready=0, then offer beats X1, X2, X3 back-to-back.
  - X1 appears at the output and X2 goes into the skid.
  - in_ready=0 from the cycle after X2 is accepted; X3 is held.
  - Raise out_ready: outputs X1, X2, X3 in order with no gaps after the first release; outputs stay stable while stalled.
- Streaming: 16 random beats with in_valid and out_ready held at 1.
  - 16 results arrive 1 cycle delayed, matching a reference model.
  - in_ready stays 1 throughout.
- Simultaneous accept and transfer in ONE: the output register updates to the new beat the same edge the old one transfers; skid_valid stays 0.
- Reset mid-operation: FULL state with out_ready=0, then assert rst_n=0 asynchronously between edges.
  - out_valid=0 and in_ready=1 immediately.
  - After release, the first new beat appears with 1-cycle latency and no stale data.
